// File: rtl/cpu_seq_ctrl_if.sv
// Control bus between the sequencing FSM and the CR16-subset datapath.
// master = the sequencer (cpu_seq_ctrl), slave = datapath / memory side.
interface cpu_seq_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_BITS   = 4
) ();
    logic                  run;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] ir;
    logic                  pc_en;
    logic                  mem_addr_sel;
    logic                  mem_we;
    logic                  rf_wr_en;
    logic [REG_BITS-1:0]   rf_addr1;
    logic [REG_BITS-1:0]   rf_addr2;
    logic                  wb_sel;
    logic [3:0]            alu_op;
    logic                  alu_src_imm;
    logic [DATA_WIDTH-1:0] imm_out;
    logic                  flags_wr_en;
    logic                  halted;
    logic [15:0]           retired;

    modport master (
        input  run, mem_rd_data,
        output ir, pc_en, mem_addr_sel, mem_we, rf_wr_en, rf_addr1, rf_addr2,
               wb_sel, alu_op, alu_src_imm, imm_out, flags_wr_en, halted, retired
    );

    modport slave (
        output run, mem_rd_data,
        input  ir, pc_en, mem_addr_sel, mem_we, rf_wr_en, rf_addr1, rf_addr2,
               wb_sel, alu_op, alu_src_imm, imm_out, flags_wr_en, halted, retired
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit CR16-subset datapath:
// FETCH -> DECODE -> EXEC [-> LOAD_WB] -> FETCH, with a sticky halt on
// illegal opcodes and a wrapping retired-instruction counter.
// The instruction encoding is fixed at 16 bits; DATA_WIDTH must stay 16.
module cpu_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_BITS   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    cpu_seq_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_LOAD_WB,
        S_HALT
    } state_e;

    localparam logic [3:0] OP_CMP = 4'hB;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic                  halted_q;
    logic [15:0]           retired_q;

    // Raw strobes before reset gating, plus bookkeeping events.
    logic pc_en_raw, mem_we_raw, rf_wr_en_raw, flags_wr_en_raw;
    logic mem_addr_sel, wb_sel, alu_src_imm;
    logic halt_set, retire;

    // Instruction fields and decode.
    logic [3:0] opcode, ext, op_sel;
    logic       is_r, is_i, is_alu, is_load, is_stor;
    logic       sign_ext;

    function automatic logic is_alu_code(input logic [3:0] c);
        case (c)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    assign opcode  = ir_q[15:12];
    assign ext     = ir_q[7:4];
    assign is_r    = (opcode == 4'h0) && is_alu_code(ext);
    assign is_i    = is_alu_code(opcode);
    assign is_alu  = is_r || is_i;
    assign is_load = (opcode == 4'h4) && (ext == 4'h0);
    assign is_stor = (opcode == 4'h4) && (ext == 4'h4);
    assign op_sel  = is_r ? ext : opcode;

    // Arithmetic immediates (ADD/SUB/CMP/MOV) are signed, logical ones unsigned.
    assign sign_ext = (opcode == 4'h5) || (opcode == 4'h9) ||
                      (opcode == 4'hB) || (opcode == 4'hD);

    // Next-state and per-state control decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_d         = state_q;
        pc_en_raw       = 1'b0;
        mem_we_raw      = 1'b0;
        rf_wr_en_raw    = 1'b0;
        flags_wr_en_raw = 1'b0;
        mem_addr_sel    = 1'b0;
        wb_sel          = 1'b0;
        alu_src_imm     = 1'b0;
        halt_set        = 1'b0;
        retire          = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (bus.run) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    alu_src_imm     = is_i;
                    rf_wr_en_raw    = (op_sel != OP_CMP);
                    flags_wr_en_raw = (op_sel == 4'h5) || (op_sel == 4'h9) || (op_sel == OP_CMP);
                    pc_en_raw       = 1'b1;
                    retire          = 1'b1;
                    state_d         = S_FETCH;
                end else if (is_load) begin
                    mem_addr_sel = 1'b1;
                    state_d      = S_LOAD_WB;
                end else if (is_stor) begin
                    mem_addr_sel = 1'b1;
                    mem_we_raw   = 1'b1;
                    pc_en_raw    = 1'b1;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    halt_set = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_LOAD_WB: begin
                wb_sel       = 1'b1;
                rf_wr_en_raw = 1'b1;
                pc_en_raw    = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, instruction register, halt flag and retired counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (!reset_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) ir_q <= bus.mem_rd_data;
            if (halt_set)            halted_q <= 1'b1;
            if (retire)              retired_q <= retired_q + 16'd1;
        end
    end

    // NOTE: reset is synchronous, so strobes are gated by reset_n to stop a write completing at the reset edge.
    assign bus.pc_en       = pc_en_raw       & reset_n;
    assign bus.mem_we      = mem_we_raw      & reset_n;
    assign bus.rf_wr_en    = rf_wr_en_raw    & reset_n;
    assign bus.flags_wr_en = flags_wr_en_raw & reset_n;

    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.wb_sel       = wb_sel;
    assign bus.alu_src_imm  = alu_src_imm;
    assign bus.alu_op       = op_sel;
    assign bus.imm_out      = sign_ext ? {{(DATA_WIDTH-8){ir_q[7]}}, ir_q[7:0]}
                                       : {{(DATA_WIDTH-8){1'b0}},    ir_q[7:0]};
    assign bus.rf_addr1     = ir_q[8 +: REG_BITS];
    assign bus.rf_addr2     = ir_q[0 +: REG_BITS];
    assign bus.ir           = ir_q;
    assign bus.halted       = halted_q;
    assign bus.retired      = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed cases followed by random
// instruction streams, compared cycle by cycle against an instruction-level model.
module tb_cpu_seq_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cpu_seq_ctrl_if bus ();
    cpu_seq_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_retired;
    logic [15:0] last_ir;

    typedef enum {K_ALU_R, K_ALU_I, K_LOAD, K_STOR, K_ILL} kind_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    function automatic bit in_alu_set(input logic [3:0] c);
        logic [3:0] tbl [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
        foreach (tbl[n]) if (tbl[n] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic kind_e classify(input logic [15:0] i);
        if (i[15:12] == 4'h0 && in_alu_set(i[7:4])) return K_ALU_R;
        if (in_alu_set(i[15:12]))                   return K_ALU_I;
        if (i[15:12] == 4'h4 && i[7:4] == 4'h0)     return K_LOAD;
        if (i[15:12] == 4'h4 && i[7:4] == 4'h4)     return K_STOR;
        return K_ILL;
    endfunction

    // Immediate value as the ALU should see it: arithmetic forms use a signed byte.
    function automatic logic [15:0] model_imm(input logic [15:0] i);
        int v;
        v = int'(i[7:0]);
        if ((i[15:12] == 4'h5 || i[15:12] == 4'h9 || i[15:12] == 4'hB || i[15:12] == 4'hD) && v > 127)
            v = v - 256;
        return 16'(v);
    endfunction

    function automatic logic [3:0] strobes();
        return {bus.pc_en, bus.mem_we, bus.rf_wr_en, bus.flags_wr_en};
    endfunction

    function automatic logic [15:0] rand_instr(input int kind);
        logic [3:0]  tbl [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
        logic [3:0]  ra, rb, code;
        logic [15:0] r;
        ra   = 4'($urandom_range(0, 15));
        rb   = 4'($urandom_range(0, 15));
        code = tbl[$urandom_range(0, 6)];
        case (kind)
            0:       r = {4'h0, ra, code, rb};
            1:       r = {code, ra, 8'($urandom_range(0, 255))};
            2:       r = {4'h4, ra, 4'h0, rb};
            3:       r = {4'h4, ra, 4'h4, rb};
            default: begin
                r = 16'($urandom);
                while (classify(r) != K_ILL) r = 16'($urandom);
            end
        endcase
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Ends at a falling edge with the DUT in FETCH and reset released.
    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        bus.run = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("reset_quiet", strobes(), 4'b0000);
        end
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
        check("reset_ir", bus.ir, 16'h0000);
        check("reset_retired", bus.retired, 16'h0000);
        check("reset_halted", bus.halted, 1'b0);
        check("reset_addr_sel", bus.mem_addr_sel, 1'b0);
        exp_retired = 16'h0000;
        last_ir     = 16'h0000;
    endtask

    // Runs one instruction from FETCH. Entered and left just after a falling edge in FETCH.
    task automatic exec_instr(input logic [15:0] instr, input int idle, input bit abort_wb);
        kind_e      k;
        logic [3:0] op;
        bit         wr, fl;
        k  = classify(instr);
        op = (k == K_ALU_R) ? instr[7:4] : instr[15:12];
        wr = (op != 4'hB);
        fl = (op == 4'h5 || op == 4'h9 || op == 4'hB);

        check("fetch_quiet", strobes(), 4'b0000);
        check("fetch_addr_sel", bus.mem_addr_sel, 1'b0);
        bus.mem_rd_data = 16'($urandom);
        if (idle > 0) begin
            bus.run = 1'b0;
            repeat (idle) begin
                @(negedge clk);
                check("idle_quiet", strobes(), 4'b0000);
                check("idle_ir", bus.ir, last_ir);
            end
        end
        bus.run = 1'b1;
        @(negedge clk);                                   // DECODE
        check("decode_quiet", strobes(), 4'b0000);
        bus.run         = 1'($urandom_range(0, 1));
        bus.mem_rd_data = instr;
        @(negedge clk);                                   // EXEC
        bus.mem_rd_data = 16'($urandom);
        check("exec_ir", bus.ir, instr);
        check("exec_addr1", bus.rf_addr1, instr[11:8]);
        check("exec_addr2", bus.rf_addr2, instr[3:0]);
        check("exec_halted", bus.halted, 1'b0);
        case (k)
            K_ALU_R, K_ALU_I: begin
                check("alu_strobes", strobes(), {1'b1, 1'b0, wr, fl});
                check("alu_op", bus.alu_op, op);
                check("alu_src_imm", bus.alu_src_imm, (k == K_ALU_I));
                check("alu_addr_sel", bus.mem_addr_sel, 1'b0);
                if (k == K_ALU_I) check("alu_imm", bus.imm_out, model_imm(instr));
                exp_retired++;
            end
            K_LOAD: begin
                check("load_exec_strobes", strobes(), 4'b0000);
                check("load_exec_addr_sel", bus.mem_addr_sel, 1'b1);
            end
            K_STOR: begin
                check("stor_strobes", strobes(), 4'b1100);
                check("stor_addr_sel", bus.mem_addr_sel, 1'b1);
                exp_retired++;
            end
            default: begin
                check("ill_exec_strobes", strobes(), 4'b0000);
            end
        endcase
        @(negedge clk);

        if (k == K_LOAD) begin                            // LOAD_WB
            if (abort_wb) begin
                reset_n = 1'b0;
                #1;
                check("abort_wb_quiet", strobes(), 4'b0000);
                @(negedge clk);
                check("abort_after_quiet", strobes(), 4'b0000);
                reset_n = 1'b1;
                #1;
                check("abort_fetch_addr_sel", bus.mem_addr_sel, 1'b0);
                check("abort_ir", bus.ir, 16'h0000);
                check("abort_retired", bus.retired, 16'h0000);
                exp_retired = 16'h0000;
                last_ir     = 16'h0000;
                return;
            end
            check("wb_strobes", strobes(), 4'b1010);
            check("wb_sel", bus.wb_sel, 1'b1);
            check("wb_addr1", bus.rf_addr1, instr[11:8]);
            exp_retired++;
            @(negedge clk);
        end

        if (k == K_ILL) begin                             // HALT
            for (int c = 0; c < 10; c++) begin
                check("halt_flag", bus.halted, 1'b1);
                check("halt_quiet", strobes(), 4'b0000);
                bus.run = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            check("halt_ir_held", bus.ir, instr);
            do_reset(1);
            return;
        end

        check("retired", bus.retired, exp_retired);
        last_ir = instr;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] directed [6] = '{16'h0352, 16'h51FF, 16'h1180, 16'hB2FF, 16'h4405, 16'h4647};
        bus.run         = 1'b1;
        bus.mem_rd_data = 16'h0000;
        reset_n         = 1'b0;

        do_reset(2);

        // Idle for 5 cycles then the directed set.
        exec_instr(directed[0], 5, 1'b0);
        foreach (directed[n]) if (n > 0) exec_instr(directed[n], 0, 1'b0);

        // Counter wrap: preload 0xFFFF while parked in FETCH, then one ADD.
        bus.run = 1'b0;
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        #1;
        exp_retired = 16'hFFFF;
        check("preload_retired", bus.retired, exp_retired);
        exec_instr(16'h0352, 1, 1'b0);
        check("wrap_zero", bus.retired, 16'h0000);

        // Reset landing in LOAD_WB, then an illegal opcode.
        exec_instr(16'h4405, 0, 1'b1);
        exec_instr(16'hF000, 0, 1'b0);

        // Random instruction stream with occasional illegal opcodes.
        for (int t = 0; t < 400; t++) begin
            int kind;
            kind = ($urandom_range(0, 39) == 0) ? 4 : int'($urandom_range(0, 3));
            exec_instr(rand_instr(kind), int'($urandom_range(0, 2)), ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit CR16-subset datapath.
- Sequences fetch, decode, execute and load-writeback.
- Drives the register file's write enable and two addresses (write targets addr1), the ALU op, immediate extension, memory strobes and PC advance.
- Holds the instruction register, a sticky illegal-opcode halt, and a retired-instruction counter.

Parameters:
- DATA_WIDTH, 16, datapath and instruction width. Must be 16; the encoding fields are fixed.
- REG_BITS, 4, register file address width. Values below 4 use the low REG_BITS of each 4-bit field.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  synchronous active-low reset
- run  in  1  level; FSM leaves FETCH only while high
- mem_rd_data  in  16  instruction/data from synchronous RAM, valid one cycle after address
- ir  out  16  instruction register
- pc_en  out  1  PC += 1 this cycle
- mem_addr_sel  out  1  0 = PC, 1 = register addressed by rf_addr2
- mem_we  out  1  store strobe; data is rd_data1
- rf_wr_en  out  1  register file write (addr1 <= write data)
- rf_addr1  out  REG_BITS  ir[11:8] (Rdest / store data)
- rf_addr2  out  REG_BITS  ir[3:0] (Rsrc / address reg)
- wb_sel  out  1  0 = ALU result, 1 = mem_rd_data
- alu_op  out  4  ir[7:4] for R-type, ir[15:12] for immediate forms
- alu_src_imm  out  1  ALU B operand = imm_out
- imm_out  out  16  extended ir[7:0]
- flags_wr_en  out  1  update C/L/F/Z/N
- halted  out  1  sticky illegal-instruction flag
- retired  out  16  retired-instruction count

Behaviour:
- Registered state: state, ir, halted, retired. All other outputs are combinational from state and ir.
- Reset (reset_n = 0 at a clock edge, any state): state = FETCH, ir = 0, halted = 0, retired = 0.
- Reset takes effect mid-instruction; no write or store completes in the reset cycle.
- Strobes (pc_en, mem_we, rf_wr_en, flags_wr_en) are 0 in every state where not listed below.
- Decoded ops:
  - R-type: opcode 0000, ext in {0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP, 1101 MOV}.
  - Immediate: opcode in the same set {0001, 0010, 0011, 0101, 1001, 1011, 1101}.
  - LOAD: opcode 0100, ext 0000.
  - STOR: opcode 0100, ext 0100.
  - Anything else is illegal.
- imm_out:
  - Sign-extended ir[7:0] for ADDI, SUBI, CMPI, MOVI.
  - Zero-extended for ANDI, ORI, XORI.
  - Don't-care otherwise.
- FETCH: mem_addr_sel = 0. If run, go to DECODE; else stay.
- DECODE: ir <= mem_rd_data. Go to EXEC.
- EXEC, ALU op:
  - alu_src_imm = 1 for immediate forms.
  - rf_wr_en = 1 except CMP/CMPI.
  - flags_wr_en = 1 for ADD, SUB, CMP (R and I forms).
  - pc_en = 1, retired += 1. Go to FETCH.
- EXEC, LOAD: mem_addr_sel = 1. Go to LOAD_WB.
- EXEC, STOR: mem_addr_sel = 1, mem_we = 1, pc_en = 1, retired += 1. Go to FETCH.
- EXEC, illegal: halted <= 1, no strobes, PC not advanced. Go to HALT.
- LOAD_WB: wb_sel = 1, rf_wr_en = 1, pc_en = 1, retired += 1. Go to FETCH.
- HALT: all strobes 0. Leave only via reset.
- Latency: ALU op and STOR take 3 cycles (FETCH→EXEC); LOAD takes 4. run is sampled in FETCH only.
- retired wraps 0xFFFF → 0x0000.
- Writes with Rdest = r0 still assert rf_wr_en. The register file hardwires r0 reads to 0.

Test Plan:
- reset_n = 0 for 2 cycles with run = 1 → state FETCH; ir = 0, retired = 0, halted = 0; all strobes 0. Then run = 0 for 5 cycles → FSM holds FETCH, pc_en never asserted.
- run = 1, mem returns 0x0352 (ADD r3,r2) → in cycle 3: rf_addr1 = 3, rf_addr2 = 2, alu_op = 0101, rf_wr_en = 1, flags_wr_en = 1, pc_en = 1, alu_src_imm = 0; retired = 1 after.
- 0x51FF (ADDI r1,#-1) → imm_out = 0xFFFF, alu_src_imm = 1. 0x1180 (ANDI r1,#0x80) → imm_out = 0x0080, flags_wr_en = 0. 0xB2FF (CMPI) → rf_wr_en = 0, flags_wr_en = 1.
- 0x4405 (LOAD r4,[r5]) → EXEC: mem_addr_sel = 1, rf_wr_en = 0. LOAD_WB: wb_sel = 1, rf_wr_en = 1, rf_addr1 = 4, pc_en = 1. 0x4647 (STOR r6,[r7]) → EXEC: mem_we = 1, rf_addr2 = 7, pc_en = 1.
- 0xF000 → halted = 1 from the cycle after EXEC; no strobes for 10 cycles. reset_n = 0 clears halted and returns to FETCH.
- Preload retired = 0xFFFF via 65535 ADDs (or force), one more ADD → retired = 0x0000. reset_n = 0 asserted in LOAD_WB → no rf_wr_en at that edge, state FETCH next cycle.
